// File: rtl/gumnut_bus_pkg.sv
// Shared Gumnut bus definitions: bus widths, wait-state limit and the state
// encodings used by the data responder and the control unit.
package gumnut_bus_pkg;

    localparam int GUMNUT_ADDR_W = 8;
    localparam int GUMNUT_DATA_W = 8;
    localparam int MAX_WAIT      = 15;
    localparam int WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } resp_state_t;

    // Control unit sequencing states, kept here so both bus ends agree on them.
    typedef enum logic [2:0] {
        CU_FETCH,
        CU_DECODE,
        CU_EXECUTE,
        CU_MEM,
        CU_MEM_WAIT,
        CU_WRITE_BACK,
        CU_INT
    } cu_state_t;

    function automatic logic addr_below(input int unsigned addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/gumnut_data_responder_if.sv
// Gumnut data bus: single-beat cyc/stb/ack transfer between the control unit
// (master) and a data-memory responder (slave).
interface gumnut_data_responder_if
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W = GUMNUT_ADDR_W,
    parameter int DATA_W = GUMNUT_DATA_W
);
    logic              data_cyc_i;
    logic              data_stb_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_adr_i;
    logic [DATA_W-1:0] data_dat_i;
    logic [DATA_W-1:0] data_dat_o;
    logic              data_ack_o;

    modport master (
        output data_cyc_i,
        output data_stb_i,
        output data_we_i,
        output data_adr_i,
        output data_dat_i,
        input  data_dat_o,
        input  data_ack_o
    );

    modport slave (
        input  data_cyc_i,
        input  data_stb_i,
        input  data_we_i,
        input  data_adr_i,
        input  data_dat_i,
        output data_dat_o,
        output data_ack_o
    );
endinterface

// File: rtl/gumnut_dmem_array.sv
// Byte-wide data memory with synchronous write and a registered read port;
// addresses at or beyond DEPTH drop stores and read back as zero.
module gumnut_dmem_array
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W = GUMNUT_ADDR_W,
    parameter int DATA_W = GUMNUT_DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_depth_check
        $error("DEPTH %0d must be in 2..2**ADDR_W", DEPTH);
    end

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] rd_data_next;
    logic [IDX_W-1:0]  idx;
    logic              in_range;

    assign in_range = addr_below(32'(addr), 32'(DEPTH));
    assign idx      = addr[IDX_W-1:0];
    assign rd_word  = mem_reg[idx];

    // Out-of-range reads are forced to zero bit by bit before the output register.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rd_mask
        assign rd_data_next[gi] = in_range & rd_word[gi];
    end

    // Storage is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem_reg[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/gumnut_data_responder.sv
// Gumnut data-bus responder: accepts a request, waits WAIT_CYCLES, commits the
// load or store to local memory and pulses ack for one cycle.
module gumnut_data_responder
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W      = GUMNUT_ADDR_W,
    parameter int DATA_W      = GUMNUT_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gumnut_data_responder_if.slave bus
);
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_wait_check
        $error("WAIT_CYCLES %0d outside 0..%0d", WAIT_CYCLES, MAX_WAIT);
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic                  NO_WAIT   = (WAIT_CYCLES == 0);

    resp_state_t           state_reg;
    logic [WAIT_CNT_W-1:0] cnt_reg;
    logic [ADDR_W-1:0]     adr_reg;
    logic                  we_reg;
    logic [DATA_W-1:0]     dat_reg;
    logic                  ack_reg;

    logic                  accept;
    logic                  commit;
    logic                  commit_we;
    logic [ADDR_W-1:0]     commit_adr;
    logic [DATA_W-1:0]     commit_dat;
    logic [WAIT_CNT_W-1:0] cnt_dec;

    // With zero wait states the commit happens on the accepting edge, so the
    // memory must see the live bus fields instead of the latched copies.
    always_comb begin
        accept     = (state_reg == IDLE) && bus.data_cyc_i && bus.data_stb_i;
        commit     = (accept && NO_WAIT) ||
                     ((state_reg == WAIT) && bus.data_cyc_i && (cnt_reg == 4'd1));
        commit_we  = (state_reg == IDLE) ? bus.data_we_i  : we_reg;
        commit_adr = (state_reg == IDLE) ? bus.data_adr_i : adr_reg;
        commit_dat = (state_reg == IDLE) ? bus.data_dat_i : dat_reg;
        cnt_dec    = (cnt_reg != '0) ? (cnt_reg - 4'd1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            adr_reg   <= '0;
            we_reg    <= 1'b0;
            dat_reg   <= '0;
            ack_reg   <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        adr_reg <= bus.data_adr_i;
                        we_reg  <= bus.data_we_i;
                        dat_reg <= bus.data_dat_i;
                        cnt_reg <= WAIT_LOAD;
                        if (commit) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_dec;
                    // Losing cyc cancels the request even on the final wait cycle.
                    if (!bus.data_cyc_i) begin
                        state_reg <= IDLE;
                    end else if (commit) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    gumnut_dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (commit && commit_we),
        .rd_en   (commit && !commit_we),
        .addr    (commit_adr),
        .wr_data (commit_dat),
        .rd_data (bus.data_dat_o)
    );

    assign bus.data_ack_o = ack_reg;

endmodule

// File: tb/tb_gumnut_data_responder.sv
// Bench for gumnut_data_responder: four instances with different wait/depth
// settings, directed scenarios plus random traffic against a memory model.
module tb_gumnut_data_responder;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc_s = 1'b0;
    logic       stb_s = 1'b0;
    logic       we_s = 1'b0;
    logic [7:0] adr_s = '0;
    logic [7:0] dat_s = '0;
    int         sel = 0;

    logic       ack_v  [NI];
    logic [7:0] dato_v [NI];
    logic       ack_sel;
    logic [7:0] dato_sel;

    int wait_m  [NI] = '{0, 1, 3, 15};
    int depth_m [NI] = '{256, 128, 256, 256};
    int mem_m   [NI][256];
    bit vld_m   [NI][256];
    int last_m  [NI];

    int total = 0;
    int passed = 0;
    int stray = 0;
    int consec = 0;
    logic prev_ack [NI] = '{1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    gumnut_data_responder_if ifs [NI] ();

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        assign ifs[gi].data_cyc_i = cyc_s & (sel == gi);
        assign ifs[gi].data_stb_i = stb_s & (sel == gi);
        assign ifs[gi].data_we_i  = we_s;
        assign ifs[gi].data_adr_i = adr_s;
        assign ifs[gi].data_dat_i = dat_s;
        assign ack_v[gi]  = ifs[gi].data_ack_o;
        assign dato_v[gi] = ifs[gi].data_dat_o;

        gumnut_data_responder #(
            .ADDR_W      (8),
            .DATA_W      (8),
            .DEPTH       ((gi == 1) ? 128 : 256),
            .WAIT_CYCLES ((gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 3 : 15)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifs[gi])
        );
    end

    assign ack_sel  = ack_v[sel];
    assign dato_sel = dato_v[sel];

    // Acks from unselected instances, or on two consecutive cycles, are errors.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ack_v[i] === 1'b1 && i != sel) stray++;
            if (ack_v[i] === 1'b1 && prev_ack[i] === 1'b1) consec++;
            prev_ack[i] = ack_v[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit load_checkable(input int i, input int adr);
        return (adr >= depth_m[i]) || vld_m[i][adr];
    endfunction

    function automatic int load_expect(input int i, input int adr);
        return (adr >= depth_m[i]) ? 0 : mem_m[i][adr];
    endfunction

    task automatic txn(input int i, input bit we, input int adr, input int dat);
        int n;
        bit got;
        int exp;
        bit can;
        exp = load_expect(i, adr);
        can = load_checkable(i, adr);
        @(negedge clk);
        sel = i; we_s = we; adr_s = 8'(adr); dat_s = 8'(dat);
        cyc_s = 1'b1; stb_s = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack_sel === 1'b1) got = 1'b1;
        end
        chk($sformatf("latency inst%0d", i), got ? n : 999, wait_m[i] + 1);
        if (we) begin
            chk($sformatf("hold inst%0d", i), dato_sel, last_m[i]);
            if (adr < depth_m[i]) begin
                mem_m[i][adr] = dat;
                vld_m[i][adr] = 1'b1;
            end
        end else if (can) begin
            chk($sformatf("rdata inst%0d adr 0x%02h", i, adr), dato_sel, exp);
            last_m[i] = exp;
        end
        $display("txn inst=%0d %s adr=0x%02h dat=0x%02h edges_to_ack=%0d dat_o=0x%02h",
                 i, we ? "store" : "load ", adr, we ? dat : int'(dato_sel), n, dato_sel);
        @(negedge clk);
        cyc_s = 1'b0; stb_s = 1'b0;
    endtask

    initial begin
        int seen;
        int ri, radr;
        bit rwe;

        for (int i = 0; i < NI; i++) last_m[i] = 0;

        // Reset values
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset ack inst%0d", i), ack_v[i], 0);
            chk($sformatf("reset dat inst%0d", i), dato_v[i], 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Initialise a pool of addresses on every instance
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 16; a++)
                txn(i, 1'b1, a, int'($urandom_range(0, 255)));

        // Store then load with one wait state
        txn(1, 1'b1, 8'h10, 8'hA5);
        txn(1, 1'b0, 8'h10, 0);
        chk("store_load_a5", dato_v[1], 8'hA5);

        // Zero-wait back-to-back loads with cyc/stb held high
        @(negedge clk);
        sel = 0; we_s = 1'b0; adr_s = 8'h00; cyc_s = 1'b1; stb_s = 1'b1;
        @(posedge clk); #1;
        chk("b2b ack0", ack_sel, 1);
        chk("b2b dat0", dato_sel, mem_m[0][0]);
        adr_s = 8'h01;
        @(posedge clk); #1;
        chk("b2b gap", ack_sel, 0);
        @(posedge clk); #1;
        chk("b2b ack1", ack_sel, 1);
        chk("b2b dat1", dato_sel, mem_m[0][1]);
        last_m[0] = mem_m[0][1];
        @(negedge clk);
        cyc_s = 1'b0; stb_s = 1'b0;

        // Abort in the second wait cycle
        txn(2, 1'b1, 8'h20, 8'h11);
        @(negedge clk);
        sel = 2; we_s = 1'b1; adr_s = 8'h20; dat_s = 8'h3C; cyc_s = 1'b1; stb_s = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc_s = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack_sel === 1'b1) seen++;
        end
        chk("abort no ack", seen, 0);
        stb_s = 1'b0;
        txn(2, 1'b0, 8'h20, 0);

        // Out of range with DEPTH=128
        txn(1, 1'b1, 8'h90, 8'hFF);
        txn(1, 1'b0, 8'h90, 0);
        chk("oor load zero", dato_v[1], 0);

        // Asynchronous reset in the middle of a long wait
        @(negedge clk);
        sel = 3; we_s = 1'b1; adr_s = 8'h05; dat_s = 8'h77; cyc_s = 1'b1; stb_s = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst wait ack", ack_v[3], 0);
        chk("rst wait dat", dato_v[3], 0);
        for (int i = 0; i < NI; i++) last_m[i] = 0;
        @(negedge clk);
        cyc_s = 1'b0; stb_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ack_v[3] === 1'b1) seen++;
        end
        chk("rst wait no ack", seen, 0);
        txn(3, 1'b0, 8'h05, 0);

        // Asynchronous reset during the ack cycle
        @(negedge clk);
        sel = 0; we_s = 1'b0; adr_s = 8'h03; cyc_s = 1'b1; stb_s = 1'b1;
        @(posedge clk); #1;
        chk("rst ack pre", ack_sel, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst ack drop", ack_v[0], 0);
        chk("rst ack dat", dato_v[0], 0);
        for (int i = 0; i < NI; i++) last_m[i] = 0;
        @(negedge clk);
        cyc_s = 1'b0; stb_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fifteen wait states: ack on the sixteenth edge
        txn(3, 1'b0, 8'h07, 0);

        // Random traffic against the model
        for (int k = 0; k < 60; k++) begin
            ri   = int'($urandom_range(0, NI - 1));
            rwe  = 1'($urandom_range(0, 1));
            radr = int'($urandom_range(0, 15));
            if (ri == 1 && $urandom_range(0, 3) == 0) radr = int'($urandom_range(128, 255));
            txn(ri, rwe, radr, int'($urandom_range(0, 255)));
        end

        repeat (2) @(negedge clk);
        chk("stray acks", stray, 0);
        chk("consecutive acks", consec, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gumnut_data_responder.md
# gumnut_data_responder

Responder end of the Gumnut data bus. Accepts classic single-beat strobe/cycle/ack transactions from the control unit's data-bus master (`data_cyc`, `data_stb`, `data_we`). Serves each from a local byte-wide data memory after a programmable number of wait states, then returns a one-cycle acknowledge. Sits between the processor datapath and on-chip data RAM, and doubles as the bench model for the control unit's memory states.

## Interface
Parameters:
- `ADDR_W`, 8: data address width.
- `DATA_W`, 8: data word width.
- `DEPTH`, 256: implemented words, ≤ 2**ADDR_W.
- `WAIT_CYCLES`, 1: wait states inserted before ack, 0..15.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_cyc_i` in 1: bus cycle in progress.
- `data_stb_i` in 1: transfer strobe.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_adr_i` in `ADDR_W`: word address.
- `data_dat_i` in `DATA_W`: store data.
- `data_dat_o` out `DATA_W`: load data. Valid while `data_ack_o` is high.
- `data_ack_o` out 1: transfer acknowledge, one-cycle pulse.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE**
  - `data_cyc_i & data_stb_i` sampled high: latch address, we and store data.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or directly to ACK when `WAIT_CYCLES` = 0.
  - Otherwise stay in IDLE.
- **WAIT**
  - Counter decrements each cycle. At counter = 1, go to ACK.
  - `data_cyc_i` low in any WAIT cycle: abort to IDLE. No write is committed and no ack is issued.
  - `data_stb_i` low with `data_cyc_i` high: keep counting. The latched request stands.
- **Commit, on the edge entering ACK**
  - Store: write latched data to latched address.
  - Load: register the memory word into `data_dat_o`.
- **ACK**
  - `data_ack_o` = 1 for exactly this cycle. Then go unconditionally to IDLE.
  - `data_dat_o` holds its last value until the next load commit.
- **Back-to-back requests:** IDLE accepts a new request in the cycle after ACK if `cyc & stb` are still high. Ack is therefore never high on two consecutive cycles.
- **Out-of-range address** (address ≥ `DEPTH`):
  - Store is discarded.
  - Load returns 0.
  - Still acknowledged with normal latency.
- Memory contents are not reset. Their power-up value is undefined.

## Timing
- **Reset values:** `data_ack_o` = 0, `data_dat_o` = 0, FSM = IDLE, counter = 0.
- **Latency:** request first sampled at edge N. `data_ack_o` is high during cycle N+1+`WAIT_CYCLES`.
- **Handshake:**
  - The master holds address, we and data stable from strobe until ack.
  - Request inputs are ignored outside IDLE.
- **Reset mid-transaction:**
  - `data_ack_o` drops asynchronously.
  - The pending store is lost.
  - Memory is untouched apart from any store already committed.
- **Reset release:** the first request is accepted no earlier than the first rising edge after `rst_n` is high.
- **Simultaneous events:**
  - `data_cyc_i` dropping in the ACK cycle does not cancel the ack or the commit.
  - Abort and counter reaching 1 in the same WAIT cycle: abort wins.
- **Widths:**
  - Counter is 4 bits and saturates at 0.
  - `WAIT_CYCLES` > 15 is an elaboration error, raised by assertion.

## Structure
- Shared package `gumnut_bus_pkg`:
  - `resp_state_t` enum {IDLE, WAIT, ACK}.
  - `GUMNUT_ADDR_W` = 8 and `GUMNUT_DATA_W` = 8.
  - `MAX_WAIT` = 15.
  - The control unit's state enum moves here too.
- Sub-module `gumnut_dmem_array`:
  - `DEPTH` × `DATA_W` storage.
  - Synchronous write enable, registered read port.
  - Owns the out-of-range masking.

## Test plan
- **Store then load, `WAIT_CYCLES`=1:** store 0xA5 to address 0x10, then load 0x10. Each ack lands at N+2 and the load returns 0xA5.
- **Zero-wait back-to-back, `WAIT_CYCLES`=0:** hold `cyc`/`stb` high across loads of 0x00 then 0x01. Acks land on alternating cycles, never on consecutive cycles.
- **Abort:** store 0x3C to 0x20 with `WAIT_CYCLES`=3, and drop `data_cyc_i` in the second WAIT cycle. No ack is issued and a later load of 0x20 returns the prior value.
- **Out of range, `DEPTH`=128:** store 0xFF to 0x90, then load 0x90. Both are acked and the load returns 0x00.
- **Async reset mid-WAIT:** assert `rst_n` low mid-WAIT during a store of 0x77 to 0x05. `data_ack_o` = 0 immediately, there is no ack after release, and 0x05 is unchanged.
- **Max wait, `WAIT_CYCLES`=15:** issue a load. Ack lands at exactly N+16.
